// File: rtl/ahb_m2s_decoder.sv
// ahb_m2s_decoder
//   Master-to-slave side of an AHB-Lite interconnect, one instance per master port.
//   - Address-phase decode of haddr_i into a one-hot hsel_o (lowest slot wins on overlap).
//   - Registered data-phase slave index steering the slave-to-master response mux.
//   - Built-in default slave answering unmapped active transfers with a two-cycle ERROR.
//   Optional build macro AHB_DEC_ERRCNT_EN adds a saturating decode-error counter and
//   a capture of the most recent erroring address. Without it those outputs are tied to 0.

// Single-slot address comparator: hit when the masked address equals the slot base.
module ahb_m2s_slot_match #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] mask,
    output logic                  hit
);

    assign hit = ((addr & mask) == base);

endmodule

module ahb_m2s_decoder #(
    parameter int                          ADDR_WIDTH = 32,
    parameter int                          SLV_CNT    = 4,
    parameter int                          IDX_W      = 5,
    parameter logic [SLV_CNT*ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [SLV_CNT*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hready_i,
    output logic [SLV_CNT-1:0]    hsel_o,
    output logic [IDX_W-1:0]      dsel_idx_o,
    output logic                  dflt_hready_o,
    output logic                  dflt_hresp_o,
    output logic                  dflt_hexokay_o,
    input  logic                  err_clr_i,
    output logic [15:0]           err_cnt_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } dflt_state_e;

    localparam logic [IDX_W-1:0] DFLT_IDX = IDX_W'(SLV_CNT);

    logic [SLV_CNT-1:0] slot_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic               dec_hit;
    logic               xfer_active;
    logic               err_start;
    logic [IDX_W-1:0]   dsel_idx_q;
    dflt_state_e        state_q;
    dflt_state_e        state_d;

    // One comparator per mapped slave slot.
    for (genvar i = 0; i < SLV_CNT; i++) begin : g_slot
        ahb_m2s_slot_match #(
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_match (
            .addr (haddr_i),
            .base (SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .mask (SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .hit  (slot_hit[i])
        );
    end

    // Priority pick of the lowest matching slot; no match selects the default slave.
    always_comb begin
        hsel_o  = '0;
        dec_idx = DFLT_IDX;
        dec_hit = 1'b0;
        for (int i = 0; i < SLV_CNT; i++) begin
            if (slot_hit[i] && !dec_hit) begin
                hsel_o[i] = 1'b1;
                dec_idx   = IDX_W'(i);
                dec_hit   = 1'b1;
            end
        end
    end

    // NONSEQ/SEQ only; IDLE and BUSY never start an error response.
    assign xfer_active = htrans_i[1];
    assign err_start   = hready_i & xfer_active & ~dec_hit;

    // Data-phase index follows the address phase whenever the bus advances.
    always_ff @(posedge hclk) begin
        if (!hresetn)
            dsel_idx_q <= DFLT_IDX;
        else if (hready_i)
            dsel_idx_q <= dec_idx;
    end

    assign dsel_idx_o = dsel_idx_q;

    // Default-slave state register.
    always_ff @(posedge hclk) begin
        if (!hresetn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Default-slave next state: ERR2 may chain straight into a new ERR1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = err_start ? ST_ERR1 : ST_IDLE;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_start ? ST_ERR1 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Default-slave Moore outputs: zero-wait OKAY in IDLE, two-cycle ERROR otherwise.
    always_comb begin
        dflt_hready_o = 1'b1;
        dflt_hresp_o  = 1'b0;
        case (state_q)
            ST_ERR1: begin
                dflt_hready_o = 1'b0;
                dflt_hresp_o  = 1'b1;
            end
            ST_ERR2: begin
                dflt_hready_o = 1'b1;
                dflt_hresp_o  = 1'b1;
            end
            default: begin
                dflt_hready_o = 1'b1;
                dflt_hresp_o  = 1'b0;
            end
        endcase
    end

    assign dflt_hexokay_o = 1'b0;

`ifdef AHB_DEC_ERRCNT_EN
    logic                  err_take;
    logic [15:0]           err_cnt_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    // A new error is exactly an entry into ERR1 (from IDLE or ERR2).
    assign err_take = err_start & (state_q != ST_ERR1);

    // Saturating error counter and last-error address; clear wins over a same-cycle error.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (err_clr_i) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (err_take) begin
            if (err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
            err_addr_q <= haddr_i;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;
`else
    assign err_cnt_o  = '0;
    assign err_addr_o = '0;
`endif

    // htrans_i[0] carries no decode meaning; err_clr_i is idle without the statistics build.
    logic unused_sink;
    assign unused_sink = htrans_i[0] ^ err_clr_i;

endmodule

// File: tb/tb_ahb_m2s_decoder.sv
// tb_ahb_m2s_decoder
//   Directed vectors with hand-computed expectations. Each applied vector pushes the
//   response expected during that cycle into a scoreboard queue; a monitor on the falling
//   edge pops and compares. Registered expectations reflect the previous vector's inputs.
//   Build with or without AHB_DEC_ERRCNT_EN; counter expectations collapse to 0 without it.
module tb_ahb_m2s_decoder;

    localparam int AW = 32;
    localparam int SC = 4;
    localparam int IW = 5;

    // Slot 1 sits inside slot 0's window to exercise lowest-index priority.
    localparam logic [SC*AW-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h0000_0100, 32'h0000_0000};
    localparam logic [SC*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hFFFF_FF00, 32'hF000_0000};

`ifdef AHB_DEC_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

    typedef struct {
        logic [SC-1:0] hsel;
        logic [IW-1:0] idx;
        logic          hrdy;
        logic          hresp;
        logic [15:0]   cnt;
        logic [AW-1:0] eaddr;
        int            vec;
    } exp_t;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hready;
    logic [SC-1:0] hsel;
    logic [IW-1:0] dsel_idx;
    logic          dflt_hready;
    logic          dflt_hresp;
    logic          dflt_hexokay;
    logic          err_clr;
    logic [15:0]   err_cnt;
    logic [AW-1:0] err_addr;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_no   = 0;

    ahb_m2s_decoder #(
        .ADDR_WIDTH (AW),
        .SLV_CNT    (SC),
        .IDX_W      (IW),
        .SLV_BASE   (BASE),
        .SLV_MASK   (MASK)
    ) dut (
        .hclk           (hclk),
        .hresetn        (hresetn),
        .haddr_i        (haddr),
        .htrans_i       (htrans),
        .hready_i       (hready),
        .hsel_o         (hsel),
        .dsel_idx_o     (dsel_idx),
        .dflt_hready_o  (dflt_hready),
        .dflt_hresp_o   (dflt_hresp),
        .dflt_hexokay_o (dflt_hexokay),
        .err_clr_i      (err_clr),
        .err_cnt_o      (err_cnt),
        .err_addr_o     (err_addr)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input int vec, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", vec, name, act, exp);
        end
    endtask

    // Monitor: compare whatever the scoreboard holds for the current cycle.
    always @(negedge hclk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("hsel",    e.vec, 32'(hsel),         32'(e.hsel));
            check("idx",     e.vec, 32'(dsel_idx),     32'(e.idx));
            check("hready",  e.vec, 32'(dflt_hready),  32'(e.hrdy));
            check("hresp",   e.vec, 32'(dflt_hresp),   32'(e.hresp));
            check("hexokay", e.vec, 32'(dflt_hexokay), 32'd0);
            check("err_cnt", e.vec, 32'(err_cnt),      32'(e.cnt));
            check("err_addr",e.vec, err_addr,          e.eaddr);
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the expected view.
    task automatic apply(input logic rst_n, input logic [AW-1:0] a, input logic [1:0] tr,
                         input logic rdy, input logic clr, input bit chk,
                         input logic [SC-1:0] x_hsel, input logic [IW-1:0] x_idx,
                         input logic x_hrdy, input logic x_hresp,
                         input logic [15:0] x_cnt, input logic [AW-1:0] x_eaddr);
        exp_t e;
        hresetn = rst_n;
        haddr   = a;
        htrans  = tr;
        hready  = rdy;
        err_clr = clr;
        if (chk) begin
            e.hsel  = x_hsel;
            e.idx   = x_idx;
            e.hrdy  = x_hrdy;
            e.hresp = x_hresp;
            e.cnt   = CNT_EN ? x_cnt   : 16'd0;
            e.eaddr = CNT_EN ? x_eaddr : '0;
            e.vec   = vec_no;
            sb.push_back(e);
        end
        vec_no++;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hresetn = 1'b0;
        haddr   = '0;
        htrans  = T_IDLE;
        hready  = 1'b1;
        err_clr = 1'b0;
        @(posedge hclk);
        #1;
        //     rst   haddr          htrans  rdy  clr chk hsel     idx  hrdy hrsp cnt  err_addr
        apply(1'b0, 32'h0000_0000, T_IDLE, 1'b1, 1'b0, 0, 4'b0001, 5'd4, 1, 0, 16'd0, 32'h0);
        // reset state visible
        apply(1'b0, 32'h2000_0010, T_NSEQ, 1'b1, 1'b0, 1, 4'b0100, 5'd4, 1, 0, 16'd0, 32'h0);
        // mapped NONSEQ to slave 2
        apply(1'b1, 32'h2000_0010, T_NSEQ, 1'b1, 1'b0, 1, 4'b0100, 5'd4, 1, 0, 16'd0, 32'h0);
        // unmapped NONSEQ; previous transfer now in data phase at slave 2
        apply(1'b1, 32'h8000_0000, T_NSEQ, 1'b1, 1'b0, 1, 4'b0000, 5'd2, 1, 0, 16'd0, 32'h0);
        // ERR1; bus stalls
        apply(1'b1, 32'h8000_0000, T_IDLE, 1'b0, 1'b0, 1, 4'b0000, 5'd4, 0, 1, 16'd1, 32'h8000_0000);
        // ERR2; master cancels with IDLE
        apply(1'b1, 32'h0000_0040, T_IDLE, 1'b1, 1'b0, 1, 4'b0001, 5'd4, 1, 1, 16'd1, 32'h8000_0000);
        // back to IDLE; index loaded even for an IDLE transfer
        apply(1'b1, 32'h8000_0000, T_NSEQ, 1'b1, 1'b0, 1, 4'b0000, 5'd0, 1, 0, 16'd1, 32'h8000_0000);
        // back-to-back errors: ERR1
        apply(1'b1, 32'h9000_0000, T_NSEQ, 1'b0, 1'b0, 1, 4'b0000, 5'd4, 0, 1, 16'd2, 32'h8000_0000);
        // ERR2 with second unmapped NONSEQ presented
        apply(1'b1, 32'h9000_0000, T_NSEQ, 1'b1, 1'b0, 1, 4'b0000, 5'd4, 1, 1, 16'd2, 32'h8000_0000);
        // straight into ERR1 again
        apply(1'b1, 32'h9000_0000, T_NSEQ, 1'b0, 1'b0, 1, 4'b0000, 5'd4, 0, 1, 16'd3, 32'h9000_0000);
        // ERR2, master goes IDLE
        apply(1'b1, 32'h3000_0000, T_IDLE, 1'b1, 1'b0, 1, 4'b1000, 5'd4, 1, 1, 16'd3, 32'h9000_0000);
        // IDLE, slave 3 decoded
        apply(1'b1, 32'h3000_0004, T_NSEQ, 1'b1, 1'b0, 1, 4'b1000, 5'd3, 1, 0, 16'd3, 32'h9000_0000);
        // hready low for three cycles while address wanders
        apply(1'b1, 32'h2000_0000, T_NSEQ, 1'b0, 1'b0, 1, 4'b0100, 5'd3, 1, 0, 16'd3, 32'h9000_0000);
        apply(1'b1, 32'h8000_0000, T_NSEQ, 1'b0, 1'b0, 1, 4'b0000, 5'd3, 1, 0, 16'd3, 32'h9000_0000);
        apply(1'b1, 32'h0000_0100, T_NSEQ, 1'b0, 1'b0, 1, 4'b0001, 5'd3, 1, 0, 16'd3, 32'h9000_0000);
        // overlap slot 0 / slot 1 -> slot 0
        apply(1'b1, 32'h0000_0100, T_NSEQ, 1'b1, 1'b0, 1, 4'b0001, 5'd3, 1, 0, 16'd3, 32'h9000_0000);
        // BUSY to unmapped: no error
        apply(1'b1, 32'h8000_0000, T_BUSY, 1'b1, 1'b0, 1, 4'b0000, 5'd0, 1, 0, 16'd3, 32'h9000_0000);
        // SEQ to unmapped: error
        apply(1'b1, 32'h8000_0000, T_SEQ,  1'b1, 1'b0, 1, 4'b0000, 5'd4, 1, 0, 16'd3, 32'h9000_0000);
        // reset asserted during ERR1
        apply(1'b0, 32'h8000_0000, T_SEQ,  1'b0, 1'b0, 1, 4'b0000, 5'd4, 0, 1, 16'd4, 32'h8000_0000);
        // reset result; error and clear in the same cycle
        apply(1'b1, 32'hA000_0000, T_NSEQ, 1'b1, 1'b1, 1, 4'b0000, 5'd4, 1, 0, 16'd0, 32'h0);
        // ERR1 taken but statistic dropped
        apply(1'b1, 32'hA000_0000, T_NSEQ, 1'b0, 1'b0, 1, 4'b0000, 5'd4, 0, 1, 16'd0, 32'h0);
        // ERR2 with new unmapped NONSEQ
        apply(1'b1, 32'hB000_0000, T_NSEQ, 1'b1, 1'b0, 1, 4'b0000, 5'd4, 1, 1, 16'd0, 32'h0);
        apply(1'b1, 32'hB000_0000, T_NSEQ, 1'b0, 1'b0, 1, 4'b0000, 5'd4, 0, 1, 16'd1, 32'hB000_0000);
        // ERR2, master idles and clears statistics
        apply(1'b1, 32'h0000_0000, T_IDLE, 1'b1, 1'b1, 1, 4'b0001, 5'd4, 1, 1, 16'd1, 32'hB000_0000);
        apply(1'b1, 32'h0000_0000, T_IDLE, 1'b1, 1'b0, 1, 4'b0001, 5'd0, 1, 0, 16'd0, 32'h0);

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge hclk);
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
